// File: rtl/multi_add_seq.sv
// ---------------------------------------------------------------------------
// multi_add      : combinational W-bit adder/subtractor slice, W = 2**S.
//   a_i, b_i     : operand words (b_i is inverted internally when sub_i=1)
//   cin_i        : carry in
//   sub_i        : 1 = subtract (a + ~b + cin)
//   sum_o, cout_o: result word and carry out
//   X            : 0 = carry-in is cin_i|sub_i, 1 = carry-in is cin_i only
//
// multi_add_seq  : streams N operand words (LS word first) through one
//   multi_add to form an N*W-bit add or subtract, chaining the carry across
//   cycles.
//   clk, rst_n           : clock, asynchronous active-low reset
//   cmd_valid/ready, cmd_sub           : operation request (0 add, 1 sub)
//   in_valid/ready, a_in, b_in         : operand word stream
//   out_valid/ready, s_out, out_last   : result word stream
//   out_cout, out_ovf    : final carry (1 = no borrow for sub) and signed
//                          overflow, meaningful with out_last
//   busy                 : operation in progress
// ---------------------------------------------------------------------------

module multi_add #(
  parameter int unsigned S = 3,
  parameter int unsigned X = 0
) (
  input  logic [(2**S)-1:0] a_i,
  input  logic [(2**S)-1:0] b_i,
  input  logic              cin_i,
  input  logic              sub_i,
  output logic [(2**S)-1:0] sum_o,
  output logic              cout_o
);

  localparam int unsigned W = 2 ** S;

  logic [W-1:0] b_eff;
  logic         cin_eff;

  assign b_eff = sub_i ? ~b_i : b_i;

  // X=1 leaves the carry-in fully under the caller's control
  if (X == 0) begin : g_cin_or
    assign cin_eff = cin_i | sub_i;
  end else begin : g_cin_direct
    assign cin_eff = cin_i;
  end

  assign {cout_o, sum_o} = {1'b0, a_i} + {1'b0, b_eff} + (W+1)'(cin_eff);

endmodule

module multi_add_seq #(
  parameter int unsigned S = 3,
  parameter int unsigned N = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              cmd_valid,
  input  logic              cmd_sub,
  output logic              cmd_ready,
  input  logic              in_valid,
  input  logic [(2**S)-1:0] a_in,
  input  logic [(2**S)-1:0] b_in,
  output logic              in_ready,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [(2**S)-1:0] s_out,
  output logic              out_last,
  output logic              out_cout,
  output logic              out_ovf,
  output logic              busy
);

  localparam int unsigned W  = 2 ** S;
  localparam int unsigned CW = (N > 1) ? $clog2(N) : 1;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } state_e;

  state_e        state_q,     state_d;
  logic [CW-1:0] cnt_q,       cnt_d;
  logic          sub_q,       sub_d;
  logic          carry_q,     carry_d;
  logic          out_valid_q, out_valid_d;
  logic [W-1:0]  s_out_q,     s_out_d;
  logic          last_q,      last_d;
  logic          cout_q,      cout_d;
  logic          ovf_q,       ovf_d;

  logic          cmd_hs;
  logic          word_hs;
  logic          is_first;
  logic          is_last;
  logic          add_cin;
  logic [W-1:0]  add_sum;
  logic          add_cout;

  // Handshake qualifiers
  assign cmd_ready = (state_q == ST_IDLE);
  assign busy      = (state_q == ST_RUN);
  // A word may enter only if the one-entry output register is free or draining
  assign in_ready  = busy && (!out_valid_q || out_ready);
  assign cmd_hs    = cmd_valid && cmd_ready;
  assign word_hs   = in_valid && in_ready;

  assign is_first  = (cnt_q == '0);
  assign is_last   = (cnt_q == CW'(N - 1));

  // Word 0 takes the +1 of two's-complement subtraction; later words chain
  assign add_cin   = is_first ? sub_q : carry_q;

  // Shared narrow adder slice
  multi_add #(
    .S (S),
    .X (1)
  ) u_add (
    .a_i    (a_in),
    .b_i    (b_in),
    .cin_i  (add_cin),
    .sub_i  (sub_q),
    .sum_o  (add_sum),
    .cout_o (add_cout)
  );

  // Next-state and output-register logic
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    sub_d       = sub_q;
    carry_d     = carry_q;
    out_valid_d = out_valid_q;
    s_out_d     = s_out_q;
    last_d      = last_q;
    cout_d      = cout_q;
    ovf_d       = ovf_q;

    unique case (state_q)
      ST_IDLE: begin
        if (cmd_hs) begin
          sub_d   = cmd_sub;
          cnt_d   = '0;
          state_d = ST_RUN;
        end
      end
      ST_RUN: begin
        if (word_hs) begin
          if (is_last) begin
            cnt_d   = '0;
            state_d = ST_IDLE;
          end else begin
            cnt_d   = cnt_q + CW'(1);
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase

    // Output register: a new word overrides a simultaneous pop
    if (word_hs) begin
      s_out_d     = add_sum;
      carry_d     = add_cout;
      out_valid_d = 1'b1;
      last_d      = is_last;
      if (is_last) begin
        cout_d = add_cout;
        // Effective B sign is inverted for subtraction
        ovf_d  = (a_in[W-1] == (b_in[W-1] ^ sub_q)) && (add_sum[W-1] != a_in[W-1]);
      end
    end else if (out_valid_q && out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  // State and output registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      sub_q       <= 1'b0;
      carry_q     <= 1'b0;
      out_valid_q <= 1'b0;
      s_out_q     <= '0;
      last_q      <= 1'b0;
      cout_q      <= 1'b0;
      ovf_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      sub_q       <= sub_d;
      carry_q     <= carry_d;
      out_valid_q <= out_valid_d;
      s_out_q     <= s_out_d;
      last_q      <= last_d;
      cout_q      <= cout_d;
      ovf_q       <= ovf_d;
    end
  end

  assign out_valid = out_valid_q;
  assign s_out     = s_out_q;
  assign out_last  = last_q;
  assign out_cout  = cout_q;
  assign out_ovf   = ovf_q;

endmodule

// File: tb/tb_multi_add_seq.sv
// ---------------------------------------------------------------------------
// Testbench for multi_add_seq: randomized operations on an S=3/N=4 instance
// checked against a wide-integer reference model, plus directed reset and
// N=1 back-to-back sequences on a second instance.
// ---------------------------------------------------------------------------

module tb_multi_add_seq;

  localparam int unsigned S  = 3;
  localparam int unsigned N  = 4;
  localparam int unsigned W  = 2 ** S;
  localparam int unsigned NW = N * W;

  typedef struct {
    logic [NW-1:0] a;
    logic [NW-1:0] b;
    logic          sub;
  } op_t;

  typedef struct {
    logic [W-1:0] s;
    logic         last;
    logic         cout;
    logic         ovf;
  } exp_t;

  logic         clk = 1'b0;
  logic         rst_n;

  logic         cmd_valid, cmd_sub, cmd_ready;
  logic         in_valid, in_ready;
  logic [W-1:0] a_in, b_in;
  logic         out_valid, out_ready, out_last, out_cout, out_ovf, busy;
  logic [W-1:0] s_out;

  logic         u1_cmd_valid, u1_cmd_sub, u1_cmd_ready;
  logic         u1_in_valid, u1_in_ready;
  logic [W-1:0] u1_a_in, u1_b_in;
  logic         u1_out_valid, u1_out_ready, u1_out_last, u1_out_cout, u1_out_ovf, u1_busy;
  logic [W-1:0] u1_s_out;

  int checks   = 0;
  int failures = 0;

  op_t  ops[$];
  exp_t expq[$];

  always #5 clk = ~clk;

  multi_add_seq #(.S(S), .N(N)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .cmd_valid (cmd_valid),
    .cmd_sub   (cmd_sub),
    .cmd_ready (cmd_ready),
    .in_valid  (in_valid),
    .a_in      (a_in),
    .b_in      (b_in),
    .in_ready  (in_ready),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .s_out     (s_out),
    .out_last  (out_last),
    .out_cout  (out_cout),
    .out_ovf   (out_ovf),
    .busy      (busy)
  );

  multi_add_seq #(.S(S), .N(1)) dut1 (
    .clk       (clk),
    .rst_n     (rst_n),
    .cmd_valid (u1_cmd_valid),
    .cmd_sub   (u1_cmd_sub),
    .cmd_ready (u1_cmd_ready),
    .in_valid  (u1_in_valid),
    .a_in      (u1_a_in),
    .b_in      (u1_b_in),
    .in_ready  (u1_in_ready),
    .out_valid (u1_out_valid),
    .out_ready (u1_out_ready),
    .s_out     (u1_s_out),
    .out_last  (u1_out_last),
    .out_cout  (u1_out_cout),
    .out_ovf   (u1_out_ovf),
    .busy      (u1_busy)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h @%0t", tag, got, exp, $time);
    end
  endtask

  // Reference: whole-operand integer arithmetic, split into result words
  function automatic void push_expected(input op_t op);
    longint unsigned ua, ub;
    longint          sa, sb, exact, smax, smin;
    logic [NW-1:0]   res;
    logic            cout, ovf;
    exp_t            e;
    ua    = longint'(op.a);
    ub    = longint'(op.b);
    sa    = longint'($signed(op.a));
    sb    = longint'($signed(op.b));
    smax  = (longint'(1) <<< (NW - 1)) - 1;
    smin  = -(longint'(1) <<< (NW - 1));
    exact = op.sub ? (sa - sb) : (sa + sb);
    res   = op.sub ? (op.a - op.b) : (op.a + op.b);
    cout  = op.sub ? (ua >= ub) : (((ua + ub) >> NW) != 0);
    ovf   = (exact > smax) || (exact < smin);
    for (int i = 0; i < int'(N); i++) begin
      e.s    = res[i*W +: W];
      e.last = (i == int'(N) - 1);
      e.cout = cout;
      e.ovf  = ovf;
      expq.push_back(e);
    end
  endfunction

  function automatic op_t mk(input logic [NW-1:0] a, input logic [NW-1:0] b, input logic sub);
    op_t o;
    o.a = a; o.b = b; o.sub = sub;
    return o;
  endfunction

  function automatic logic [NW-1:0] rnd_operand();
    logic [NW-1:0] v;
    case ($urandom_range(0, 5))
      0:       v = '0;
      1:       v = '1;
      2:       v = {1'b0, {(NW-1){1'b1}}};
      3:       v = {1'b1, {(NW-1){1'b0}}};
      default: v = NW'($urandom);
    endcase
    return v;
  endfunction

  // Drive queued ops with random gaps/backpressure and score every result
  task automatic run_ops(input int max_cycles);
    int           cyc       = 0;
    bit           word_ph   = 1'b0;
    int           widx      = 0;
    op_t          cur;
    bit           hold_prev = 1'b0;
    logic [W-1:0] hold_s    = '0;
    logic         hold_last = 1'b0;
    exp_t         e;
    cur = mk('0, '0, 1'b0);
    while ((ops.size() > 0 || word_ph || expq.size() > 0) && cyc < max_cycles) begin
      @(negedge clk);
      cyc++;
      out_ready = ($urandom_range(0, 3) != 0);
      if (word_ph) begin
        cmd_valid = ($urandom_range(0, 3) == 0);
        cmd_sub   = 1'($urandom);
        in_valid  = ($urandom_range(0, 3) != 0);
        a_in      = cur.a[widx*W +: W];
        b_in      = cur.b[widx*W +: W];
      end else begin
        cmd_valid = (ops.size() > 0) && ($urandom_range(0, 2) != 0);
        cmd_sub   = (ops.size() > 0) ? ops[0].sub : 1'b0;
        in_valid  = ($urandom_range(0, 3) == 0);
        a_in      = W'($urandom);
        b_in      = W'($urandom);
      end
      #1;
      if (hold_prev) begin
        check("hold_valid", 64'(out_valid), 64'd1);
        check("hold_s",     64'(s_out),     64'(hold_s));
        check("hold_last",  64'(out_last),  64'(hold_last));
      end
      if (out_valid && !out_ready) check("bp_in_ready", 64'(in_ready), 64'd0);
      hold_prev = out_valid && !out_ready;
      hold_s    = s_out;
      hold_last = out_last;
      if (out_valid && out_ready) begin
        if (expq.size() == 0) begin
          check("spurious_out", 64'(out_valid), 64'd0);
        end else begin
          e = expq.pop_front();
          check("s_out", 64'(s_out), 64'(e.s));
          check("last",  64'(out_last), 64'(e.last));
          if (e.last) begin
            check("cout", 64'(out_cout), 64'(e.cout));
            check("ovf",  64'(out_ovf),  64'(e.ovf));
          end
        end
      end
      if (word_ph) begin
        check("cmd_ready_run", 64'(cmd_ready), 64'd0);
        if (in_valid && in_ready) begin
          widx++;
          if (widx == int'(N)) word_ph = 1'b0;
        end
      end else begin
        check("in_ready_idle", 64'(in_ready), 64'd0);
        if (cmd_valid && cmd_ready) begin
          cur = ops.pop_front();
          push_expected(cur);
          word_ph = 1'b1;
          widx    = 0;
        end
      end
    end
    check("drain_timeout", 64'(ops.size() + expq.size()), 64'd0);
    @(negedge clk);
    cmd_valid = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    ops.delete();
    expq.delete();
  endtask

  initial begin
    rst_n     = 1'b0;
    cmd_valid = 1'b0; cmd_sub = 1'b0; in_valid = 1'b0;
    a_in      = '0;   b_in    = '0;   out_ready = 1'b0;
    u1_cmd_valid = 1'b0; u1_cmd_sub = 1'b0; u1_in_valid = 1'b0;
    u1_a_in      = '0;   u1_b_in    = '0;   u1_out_ready = 1'b0;

    #12;
    check("rst_cmd_ready", 64'(cmd_ready), 64'd1);
    check("rst_busy",      64'(busy),      64'd0);
    check("rst_in_ready",  64'(in_ready),  64'd0);
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_s_out",     64'(s_out),     64'd0);
    check("rst_flags",     64'({out_last, out_cout, out_ovf}), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // Directed cases, then randomized ones
    ops.push_back(mk(32'h00FF_FFFF, 32'h0000_0001, 1'b0));
    ops.push_back(mk(32'h0000_0000, 32'h0000_0001, 1'b1));
    ops.push_back(mk(32'h0000_0005, 32'h0000_0001, 1'b1));
    ops.push_back(mk(32'h7FFF_FFFF, 32'h0000_0001, 1'b0));
    ops.push_back(mk(32'h8000_0000, 32'h0000_0001, 1'b1));
    for (int i = 0; i < 60; i++) ops.push_back(mk(rnd_operand(), rnd_operand(), 1'($urandom)));
    run_ops(5000);

    // Reset in the middle of a subtraction
    @(negedge clk);
    cmd_valid = 1'b1; cmd_sub = 1'b1; out_ready = 1'b1;
    @(negedge clk);
    cmd_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      in_valid = 1'b1; a_in = W'(8'h10 + i); b_in = W'(8'h20 + i);
      @(negedge clk);
    end
    in_valid = 1'b0;
    #1;
    check("pre_rst_busy", 64'(busy), 64'd1);
    #1;
    rst_n = 1'b0;
    #1;
    check("mid_rst_cmd_ready", 64'(cmd_ready), 64'd1);
    check("mid_rst_busy",      64'(busy),      64'd0);
    check("mid_rst_in_ready",  64'(in_ready),  64'd0);
    check("mid_rst_out_valid", 64'(out_valid), 64'd0);
    check("mid_rst_s_out",     64'(s_out),     64'd0);
    check("mid_rst_flags",     64'({out_last, out_cout, out_ovf}), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    ops.push_back(mk(32'h0000_0001, 32'h0000_0001, 1'b0));
    run_ops(200);

    // N=1: second command accepted in the cycle the first result pops
    @(negedge clk);
    u1_cmd_valid = 1'b1; u1_cmd_sub = 1'b0; u1_out_ready = 1'b1;
    #1;
    check("n1_cmd_ready0", 64'(u1_cmd_ready), 64'd1);
    @(negedge clk);
    u1_cmd_valid = 1'b0;
    u1_in_valid  = 1'b1; u1_a_in = 8'hFF; u1_b_in = 8'h01;
    #1;
    check("n1_in_ready0", 64'(u1_in_ready), 64'd1);
    @(negedge clk);
    u1_in_valid  = 1'b0;
    u1_cmd_valid = 1'b1; u1_cmd_sub = 1'b1;
    #1;
    check("n1_s0",         64'(u1_s_out),     64'h00);
    check("n1_valid0",     64'(u1_out_valid), 64'd1);
    check("n1_last0",      64'(u1_out_last),  64'd1);
    check("n1_cout0",      64'(u1_out_cout),  64'd1);
    check("n1_cmd_ready1", 64'(u1_cmd_ready), 64'd1);
    @(negedge clk);
    u1_cmd_valid = 1'b0;
    u1_in_valid  = 1'b1; u1_a_in = 8'h03; u1_b_in = 8'h05;
    #1;
    check("n1_popped",    64'(u1_out_valid), 64'd0);
    check("n1_in_ready1", 64'(u1_in_ready),  64'd1);
    @(negedge clk);
    u1_in_valid = 1'b0;
    #1;
    check("n1_s1",     64'(u1_s_out),    64'hFE);
    check("n1_last1",  64'(u1_out_last), 64'd1);
    check("n1_cout1",  64'(u1_out_cout), 64'd0);
    check("n1_ovf1",   64'(u1_out_ovf),  64'd0);
    check("n1_idle",   64'(u1_busy),     64'd0);

    repeat (3) @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/multi_add_seq.md
# multi_add_seq

Sequencer that performs N-word (N·2**S-bit) addition or subtraction by streaming operand words, least significant first, through one `multi_add` instance of width 2**S. It chains the carry across cycles in a register and handles the first-word +1 for subtraction. It adds valid/ready handshakes on command, operand and result streams, and reports final carry and signed overflow. It sits between a wide-operand requester (register file or DMA) and the shared narrow adder datapath.

## Interface
- `S`, default 3: adder word width is W = 2**S bits; passed to `multi_add`.
- `N`, default 4: words per operand, N ≥ 1; counter width is max(1, clog2(N)).
- `clk` in 1: single clock, rising edge.
- `rst_n` in 1: reset, asynchronous, active-low.
- `cmd_valid` in 1: request to start an operation.
- `cmd_sub` in 1: 0 = A+B, 1 = A−B; sampled on cmd handshake.
- `cmd_ready` out 1: operation can be accepted.
- `in_valid` in 1: `a_in`/`b_in` hold the next operand word.
- `a_in` in W: operand A word.
- `b_in` in W: operand B word, not inverted by the requester.
- `in_ready` out 1: word accepted this cycle if `in_valid`.
- `out_valid` out 1: `s_out` holds a result word.
- `out_ready` in 1: consumer takes the result word.
- `s_out` out W: result word.
- `out_last` out 1: `s_out` is word N−1.
- `out_cout` out 1: final carry out; for subtraction, 1 = no borrow. Meaningful when `out_last`.
- `out_ovf` out 1: two's-complement overflow of the full N·W result. Meaningful when `out_last`.
- `busy` out 1: state is RUN.

## Operation
- Datapath:
  - `multi_add` is instantiated with X=1, so there is no internal cin|sub OR.
  - `sub` is driven from `sub_q`. The adder inverts b internally.
  - Adder cin = `sub_q` on word 0, `carry_q` on later words.
- FSM has two states:
  - IDLE: `cmd_ready`=1. A cmd handshake latches `sub_q`, clears `cnt`, and moves to RUN.
  - RUN: accepts words. Accepting word `cnt`==N−1 moves to IDLE.
- `in_ready` = (state==RUN) && (!out_valid || out_ready).
- On each word handshake:
  - `s_out` ← adder sum.
  - `carry_q` ← adder cout.
  - `out_valid` ← 1.
  - `out_last` ← (cnt==N−1).
  - On the last word only: `out_cout` ← adder cout, and `out_ovf` ← (a_msb == b_msb^sub_q) && (sum_msb != a_msb).
  - `cnt` ← cnt+1, wrapping to 0 after N−1.
- If `out_valid` && `out_ready` with no new word accepted, then `out_valid` ← 0.
- A pop and a new word in the same cycle keep `out_valid`=1 with the new data.
- One-entry output register. The final result may still be pending while the block is in IDLE. A new command is then accepted, but its first word waits on `in_ready`.
- `cmd_valid` is ignored in RUN. `in_valid` is ignored in IDLE. Operand words are never dropped or duplicated.
- Async reset mid-operation abandons the operation with no partial outputs retained. `carry_q` cleared, so nothing leaks into the next operation.

## Timing
- Reset values:
  - state IDLE, `cnt` 0, `sub_q` 0, `carry_q` 0.
  - `cmd_ready` 1, `busy` 0, `in_ready` 0.
  - `out_valid` 0, `s_out` 0, `out_last` 0, `out_cout` 0, `out_ovf` 0.
- Command handshake at edge t: `busy`=1 and `in_ready` may be 1 from cycle t+1.
- Word handshake at edge k: `s_out`, `out_valid` and flags are valid from cycle k+1 (latency 1).
- Throughput is 1 word/cycle with `out_ready` held high.
- A full operation takes N cycles of words, plus 1 to the last result, plus 1 command cycle.
- After the last word the state returns to IDLE at the next cycle. The next command can be accepted in the cycle the last result is popped.
- Result flags are stable while `out_valid`=1 and `out_ready`=0.
- N=1: word 0 is both first (cin=`sub_q`) and last.

## Test plan
- S=3, N=4, add. A words FF,FF,FF,00 plus B words 01,00,00,00 → s 00,00,00,01; `out_last` only on 4th word; cout=0, ovf=0.
- Subtraction:
  - 0x00000000 − 0x00000001 → FF,FF,FF,FF; cout=0 (borrow), ovf=0.
  - 0x00000005 − 0x00000001 → 04,00,00,00; cout=1.
- Signed overflow:
  - 0x7FFFFFFF + 1 → 00,00,00,80; ovf=1, cout=0.
  - 0x80000000 − 1 → FF,FF,FF,7F; ovf=1.
- Backpressure: hold `out_ready`=0 for 3 cycles after word 1 → `in_ready`=0 throughout, `s_out` unchanged, all 4 words later correct and in order.
- Reset: assert `rst_n`=0 after word 2 of a subtraction → all outputs at reset values immediately. A following 1+1 add yields 02,00,00,00 (no carry or sub leak).
- N=1, back-to-back: issue a command in the cycle the previous last result pops → accepted. Results FF+01 → 00 with cout=1, then 03−05 → FE with cout=0, ovf=0.
